// File: rtl/demux_stream_1to2.sv
// 1-to-2 valid/ready stream demultiplexer with a 2-entry FIFO per output channel.
// Optional per-channel pop counters enabled by DEMUX_STREAM_STATS_EN.
module demux_stream_1to2 #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
`ifdef DEMUX_STREAM_STATS_EN
  output logic [7:0]       stat0,
  output logic [7:0]       stat1,
`endif
  input  logic             out1_ready
);

  logic [1:0]       cnt_q   [2];
  logic [1:0]       cnt_d   [2];
  logic             wptr_q  [2];
  logic             wptr_d  [2];
  logic             rptr_q  [2];
  logic             rptr_d  [2];
  logic [WIDTH-1:0] mem_q   [2][2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       rdy;

  // in_ready looks only at registered count, never at the consumer ready inputs.
  always_comb begin
    rdy      = {out1_ready, out0_ready};
    in_ready = !flush && (cnt_q[in_sel] != 2'd2);
    push     = '0;
    pop      = '0;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      push[ch]   = in_valid && in_ready && (in_sel == 1'(ch));
      pop[ch]    = (cnt_q[ch] != 2'd0) && rdy[ch];
      cnt_d[ch]  = cnt_q[ch];
      if (push[ch] && !pop[ch])
        cnt_d[ch] = cnt_q[ch] + 2'd1;
      else if (pop[ch] && !push[ch])
        cnt_d[ch] = cnt_q[ch] - 2'd1;
      wptr_d[ch] = wptr_q[ch] ^ push[ch];
      rptr_d[ch] = rptr_q[ch] ^ pop[ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt_q[ch]  <= '0;
        wptr_q[ch] <= 1'b0;
        rptr_q[ch] <= 1'b0;
        for (int unsigned e = 0; e < 2; e++)
          mem_q[ch][e] <= '0;
      end
    end else if (flush) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt_q[ch]  <= '0;
        wptr_q[ch] <= 1'b0;
        rptr_q[ch] <= 1'b0;
        for (int unsigned e = 0; e < 2; e++)
          mem_q[ch][e] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt_q[ch]  <= cnt_d[ch];
        wptr_q[ch] <= wptr_d[ch];
        rptr_q[ch] <= rptr_d[ch];
        if (push[ch])
          mem_q[ch][wptr_q[ch]] <= in_data;
      end
    end
  end

  assign out0_valid = (cnt_q[0] != 2'd0);
  assign out1_valid = (cnt_q[1] != 2'd0);
  assign out0_data  = out0_valid ? mem_q[0][rptr_q[0]] : '0;
  assign out1_data  = out1_valid ? mem_q[1][rptr_q[1]] : '0;

`ifdef DEMUX_STREAM_STATS_EN
  logic [7:0] stat_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 2; ch++)
        stat_q[ch] <= '0;
    end else if (flush) begin
      for (int unsigned ch = 0; ch < 2; ch++)
        stat_q[ch] <= '0;
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++)
        if (pop[ch] && (stat_q[ch] != 8'hFF))
          stat_q[ch] <= stat_q[ch] + 8'd1;
    end
  end

  assign stat0 = stat_q[0];
  assign stat1 = stat_q[1];
`endif

endmodule

// File: tb/tb_demux_stream_1to2.sv
// Randomized and directed bench for demux_stream_1to2 against a queue-based model.
// Build with +define+DEMUX_STREAM_STATS_EN to also check the pop counters.
module tb_demux_stream_1to2;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_sel, in_ready;
  logic [W-1:0] in_data, out0_data, out1_data;
  logic         out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef DEMUX_STREAM_STATS_EN
  logic [7:0]   stat0, stat1;
`endif

  demux_stream_1to2 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data),
`ifdef DEMUX_STREAM_STATS_EN
    .stat0(stat0), .stat1(stat1),
`endif
    .out1_ready(out1_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int unsigned  s0 = 0, s1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    return !flush && ((in_sel ? q1.size() : q0.size()) != 2);
  endfunction

  task automatic check_outputs();
    check("in_ready",   32'(in_ready),   32'(exp_ready()));
    check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    check("out0_data",  32'(out0_data),  32'(q0.size() != 0 ? q0[0] : '0));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    check("out1_data",  32'(out1_data),  32'(q1.size() != 0 ? q1[0] : '0));
`ifdef DEMUX_STREAM_STATS_EN
    check("stat0", 32'(stat0), 32'(s0));
    check("stat1", 32'(stat1), 32'(s1));
`endif
  endtask

  function automatic void model_clear();
    q0.delete();
    q1.delete();
    s0 = 0;
    s1 = 0;
  endfunction

  // Entered just after a rising edge; drives, checks at negedge, then advances the model.
  task automatic step(input logic f, input logic v, input logic sel, input logic [W-1:0] d,
                      input logic r0, input logic r1);
    logic acc;
    flush = f; in_valid = v; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    @(negedge clk);
    check_outputs();
    acc = v && exp_ready();
    @(posedge clk);
    if (f) begin
      model_clear();
    end else begin
      if (q0.size() != 0 && r0) begin void'(q0.pop_front()); if (s0 < 255) s0++; end
      if (q1.size() != 0 && r1) begin void'(q1.pop_front()); if (s1 < 255) s1++; end
      if (acc) begin
        if (sel) q1.push_back(d);
        else     q0.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Routing
    step(0, 1, 0, 5'h0A, 1, 1);
    step(0, 1, 1, 5'h15, 1, 1);
    step(0, 0, 0, 5'h00, 1, 1);
    step(0, 0, 0, 5'h00, 1, 1);

    // Backpressure on channel 0
    step(0, 1, 0, 5'h01, 0, 0);
    step(0, 1, 0, 5'h02, 0, 0);
    step(0, 1, 0, 5'h03, 0, 0);
    check("full_refuse", 32'(q0.size()), 32'd2);
    step(0, 1, 1, 5'h07, 0, 1);
    step(0, 1, 0, 5'h03, 1, 1);
    step(0, 1, 0, 5'h03, 1, 1);
    step(0, 0, 0, 5'h00, 1, 1);
    step(0, 0, 0, 5'h00, 1, 1);

    // Push and pop together at count 1 on channel 1
    step(0, 1, 1, 5'h11, 0, 0);
    step(0, 1, 1, 5'h12, 0, 1);
    step(0, 0, 1, 5'h00, 0, 0);
    check("pp_count1", 32'(q1.size()), 32'd1);
    step(0, 0, 0, 5'h00, 1, 1);

    // Flush with both FIFOs full and a word offered
    step(0, 1, 0, 5'h04, 0, 0);
    step(0, 1, 0, 5'h05, 0, 0);
    step(0, 1, 1, 5'h06, 0, 0);
    step(0, 1, 1, 5'h08, 0, 0);
    step(1, 1, 0, 5'h09, 1, 0);
    step(0, 0, 0, 5'h00, 0, 0);
    check("flush_empty", 32'(out0_valid | out1_valid), 32'd0);

    // Long channel-0 stream: 300 pops
    for (int i = 0; i < 301; i++)
      step(0, 1'(i < 300), 0, 5'($urandom), 1, 0);
`ifdef DEMUX_STREAM_STATS_EN
    @(negedge clk);
    check("stat0_sat", 32'(stat0), 32'd255);
    check("stat1_zero", 32'(stat1), 32'd0);
    @(posedge clk); #1;
`endif

    // Random traffic with occasional flush and mid-cycle async reset
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 400) == 0) begin
        step(0, 1, 1'($urandom), 5'($urandom), 0, 0);
        step(0, 1, 1'($urandom), 5'($urandom), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("arst_v0", 32'(out0_valid), 32'd0);
        check("arst_d1", 32'(out1_data),  32'd0);
        check("arst_v1", 32'(out1_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      step(1'(($urandom % 40) == 0), 1'($urandom), 1'($urandom), 5'($urandom),
           1'(($urandom % 4) != 0), 1'(($urandom % 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
